// File: rtl/op_unload_256_pkg.sv
// op_unload_256_pkg: shared operand geometry and unloader FSM states
package op_unload_256_pkg;
  localparam int OP_W = 256;
  localparam int WORD_W = 16;
  localparam int NWORDS = 16;
  typedef enum logic {IDLE, SEND} state_t;
endpackage

// File: rtl/op_word_mux.sv
// op_word_mux: combinational NWORDS:1 word select with optional MSW-first ordering
module op_word_mux #(
  parameter int WORD_W = 16,
  parameter int NWORDS = 16,
  parameter bit MSW_FIRST = 1'b0
) (
  input  logic [WORD_W*NWORDS-1:0]   data,
  input  logic [$clog2(NWORDS)-1:0] sel,
  output logic [WORD_W-1:0]          word
);
  localparam int IW = $clog2(NWORDS);
  logic [IW-1:0] k;
  always_comb begin
    k = MSW_FIRST ? IW'(NWORDS-1) - sel : sel;
    word = '0;
    for (int i = 0; i < NWORDS; i++)
      if (k == IW'(i)) word = data[i*WORD_W +: WORD_W];
  end
endmodule

// File: rtl/op_unload_256.sv
// op_unload_256: captures a 256-bit operand and streams it out as 16-bit words over valid/ready
module op_unload_256
  import op_unload_256_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int NWORDS = 16,
  parameter bit MSW_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [WORD_W*NWORDS-1:0] load_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WORD_W-1:0]        out_data,
  output logic                     out_last,
  output logic                     busy
);
  localparam int IW = $clog2(NWORDS);
  localparam logic [IW-1:0] LAST = IW'(NWORDS-1);
  state_t state, state_nxt;
  logic [WORD_W*NWORDS-1:0] hold;
  logic [IW-1:0] idx;
  logic [WORD_W-1:0] word;
  op_word_mux #(.WORD_W(WORD_W), .NWORDS(NWORDS), .MSW_FIRST(MSW_FIRST)) u_mux (
    .data(hold),
    .sel (idx),
    .word(word)
  );
  always_comb begin
    state_nxt = flush ? IDLE
              : state == IDLE ? (load_valid ? SEND : IDLE)
              : (out_ready && idx == LAST) ? IDLE : SEND;
    load_ready = state == IDLE;
    out_valid = state == SEND;
    busy = state == SEND;
    out_last = state == SEND && idx == LAST;
    out_data = state == SEND ? word : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      hold <= '0;
    end else begin
      state <= state_nxt;
      if (flush) idx <= '0;
      else if (state == IDLE && load_valid) begin
        hold <= load_data;
        idx <= '0;
      end else if (state == SEND && out_ready && idx != LAST) idx <= idx + 1'b1;
    end
  end
endmodule
